// File: rtl/alu_pkg.sv
// Shared definitions for the calculator ALU: opcode encodings and default datapath width.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 8;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;

endpackage

// File: rtl/alu8_core.sv
// Combinational ALU function: maps opcode and operands to a result and carry/borrow flag.
module alu8_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [2:0]       opt,
  input  logic [WIDTH-1:0] numa,
  input  logic [WIDTH-1:0] numb,
  input  logic             ci,
  output logic [WIDTH-1:0] res,
  output logic             carry
);

  logic [WIDTH:0] wide_a;
  logic [WIDTH:0] wide_b;
  logic [WIDTH:0] wide_c;
  logic [WIDTH:0] wide_r;

  assign wide_a = {1'b0, numa};
  assign wide_b = {1'b0, numb};
  assign wide_c = {{WIDTH{1'b0}}, ci};

  always_comb begin
    wide_r = '0;
    unique case (opt)
      OP_ADD:  wide_r = wide_a + wide_b + wide_c;
      // Difference spans [-2^WIDTH, 2^WIDTH-1], so the top bit is set exactly on borrow.
      OP_SUB:  wide_r = wide_a - wide_b - wide_c;
      OP_AND:  wide_r = {1'b0, numa & numb};
      OP_OR:   wide_r = {1'b0, numa | numb};
      OP_XOR:  wide_r = {1'b0, numa ^ numb};
      default: wide_r = '0;
    endcase
  end

  assign res   = wide_r[WIDTH-1:0];
  assign carry = wide_r[WIDTH];

endmodule

// File: rtl/alu8.sv
// Registered ALU: samples operands on in_valid and presents result and flags one cycle later.
module alu8
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [2:0]       opt,
  input  logic [WIDTH-1:0] numa,
  input  logic [WIDTH-1:0] numb,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             zero,
  output logic             co,
  output logic             out_valid
);

  logic [WIDTH-1:0] core_res;
  logic             core_carry;

  logic [WIDTH-1:0] s_d, s_q;
  logic             zero_d, zero_q;
  logic             co_d, co_q;
  logic             out_valid_d, out_valid_q;

  alu8_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .opt  (opt),
    .numa (numa),
    .numb (numb),
    .ci   (ci),
    .res  (core_res),
    .carry(core_carry)
  );

  always_comb begin
    s_d         = s_q;
    zero_d      = zero_q;
    co_d        = co_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      s_d         = core_res;
      // Taken from the next-state result so the flag always tracks the s loaded alongside it.
      zero_d      = (core_res == '0);
      co_d        = core_carry;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q         <= '0;
      zero_q      <= 1'b1;
      co_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s_q         <= s_d;
      zero_q      <= zero_d;
      co_q        <= co_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign s         = s_q;
  assign zero      = zero_q;
  assign co        = co_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu8.sv
// Self-checking bench for alu8: directed opcode vectors, reset, hold and a randomized stream.
module tb_alu8;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] opt;
  logic [7:0] numa;
  logic [7:0] numb;
  logic       ci;
  logic [7:0] s;
  logic       zero;
  logic       co;
  logic       out_valid;

  int checks;
  int failures;

  alu8 #(
    .WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .opt      (opt),
    .numa     (numa),
    .numb     (numb),
    .ci       (ci),
    .s        (s),
    .zero     (zero),
    .co       (co),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the opcode table; returns {co, s}.
  function automatic logic [8:0] ref_alu(input int op, input int a, input int b, input int c);
    int t;
    logic [8:0] r;
    r = '0;
    case (op)
      1: begin
        t = a + b + c;
        r[7:0] = 8'(t % 256);
        r[8]   = (t > 255);
      end
      2: begin
        t = a - b - c;
        r[7:0] = 8'((t + 512) % 256);
        r[8]   = (a < b + c);
      end
      3: r[7:0] = 8'(a & b);
      4: r[7:0] = 8'(a | b);
      5: r[7:0] = 8'(a ^ b);
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic apply(input logic v, input int op, input int a, input int b, input int c);
    @(negedge clk);
    in_valid = v;
    opt      = 3'(op);
    numa     = 8'(a);
    numb     = 8'(b);
    ci       = 1'(c);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if ({s, zero, co, out_valid} !== {8'd0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_initial got s=%0d z=%0b co=%0b ov=%0b want s=0 z=1 co=0 ov=0",
               s, zero, co, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b1, 1, 100, 50, 0);
    checks++;
    if ({s, zero, co, out_valid} !== {8'd150, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_first_req got s=%0d z=%0b co=%0b ov=%0b want s=150 z=0 co=0 ov=1",
               s, zero, co, out_valid);
    end
    // Assert reset mid-cycle while a valid request is presented.
    @(negedge clk);
    in_valid = 1'b1;
    opt      = 3'd1;
    numa     = 8'd200;
    numb     = 8'd100;
    ci       = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s, zero, co, out_valid} !== {8'd0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_async got s=%0d z=%0b co=%0b ov=%0b want s=0 z=1 co=0 ov=0",
               s, zero, co, out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({s, zero, co, out_valid} !== {8'd0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_held got s=%0d z=%0b co=%0b ov=%0b want s=0 z=1 co=0 ov=0",
               s, zero, co, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b1, 1, 3, 4, 0);
    checks++;
    if ({s, zero, co, out_valid} !== {8'd7, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_release got s=%0d z=%0b co=%0b ov=%0b want s=7 z=0 co=0 ov=1",
               s, zero, co, out_valid);
    end
  endtask

  task automatic test_arith();
    // op, a, b, ci, expected s, expected co
    int tv[9][6] = '{
      '{1, 3, 5, 0, 8, 0},
      '{1, 55, 254, 0, 53, 1},
      '{1, 200, 144, 0, 88, 1},
      '{1, 255, 0, 1, 0, 1},
      '{2, 6, 12, 0, 250, 1},
      '{2, 172, 36, 0, 136, 0},
      '{2, 250, 12, 0, 238, 0},
      '{2, 200, 144, 0, 56, 0},
      '{2, 5, 6, 1, 254, 1}
    };
    for (int i = 0; i < 9; i++) begin
      apply(1'b1, tv[i][0], tv[i][1], tv[i][2], tv[i][3]);
      checks++;
      if ({s, co, zero, out_valid} !==
          {8'(tv[i][4]), 1'(tv[i][5]), (tv[i][4] == 0), 1'b1}) begin
        failures++;
        $display("FAIL arith_%0d op=%0d got s=%0d co=%0b z=%0b ov=%0b want s=%0d co=%0d z=%0b ov=1",
                 i, tv[i][0], s, co, zero, out_valid, tv[i][4], tv[i][5], tv[i][4] == 0);
      end
    end
  endtask

  task automatic test_logic();
    // op, a, b, expected s; all applied with ci=1
    int tv[5][4] = '{
      '{3, 8'h55, 8'hAA, 0},
      '{4, 8'h55, 8'hAA, 255},
      '{5, 3, 172, 175},
      '{5, 96, 54, 86},
      '{5, 4, 4, 0}
    };
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, tv[i][0], tv[i][1], tv[i][2], 1);
      checks++;
      if ({s, co, zero, out_valid} !== {8'(tv[i][3]), 1'b0, (tv[i][3] == 0), 1'b1}) begin
        failures++;
        $display("FAIL logic_%0d op=%0d got s=%0d co=%0b z=%0b ov=%0b want s=%0d co=0 z=%0b ov=1",
                 i, tv[i][0], s, co, zero, out_valid, tv[i][3], tv[i][3] == 0);
      end
    end
  endtask

  task automatic test_nop_reserved();
    int ops[3] = '{0, 6, 7};
    for (int i = 0; i < 3; i++) begin
      // Load a nonzero result first so a stuck value would be visible.
      apply(1'b1, 1, 10, 20, 0);
      apply(1'b1, ops[i], 255, 255, 1);
      checks++;
      if ({s, co, zero, out_valid} !== {8'd0, 1'b0, 1'b1, 1'b1}) begin
        failures++;
        $display("FAIL nop_res op=%0d got s=%0d co=%0b z=%0b ov=%0b want s=0 co=0 z=1 ov=1",
                 ops[i], s, co, zero, out_valid);
      end
    end
  endtask

  task automatic test_hold();
    apply(1'b1, 2, 5, 6, 0);
    checks++;
    if ({s, co, zero, out_valid} !== {8'd255, 1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL hold_load got s=%0d co=%0b z=%0b ov=%0b want s=255 co=1 z=0 ov=1",
               s, co, zero, out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 1));
      checks++;
      if ({s, co, zero, out_valid} !== {8'd255, 1'b1, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL hold_%0d got s=%0d co=%0b z=%0b ov=%0b want s=255 co=1 z=0 ov=0",
                 i, s, co, zero, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp_r;
    logic       exp_z;
    logic       v;
    int         op, a, b, c;
    exp_r = {co, s};
    exp_z = zero;
    for (int i = 0; i < 300; i++) begin
      v  = (i < 100) ? 1'b1 : ($urandom_range(0, 3) != 0);
      op = $urandom_range(0, 7);
      a  = (i % 17 == 0) ? 255 : $urandom_range(0, 255);
      b  = (i % 13 == 0) ? a : $urandom_range(0, 255);
      c  = $urandom_range(0, 1);
      apply(v, op, a, b, c);
      if (v) begin
        exp_r = ref_alu(op, a, b, c);
        exp_z = (exp_r[7:0] == 8'd0);
      end
      checks++;
      if ({s, co, zero, out_valid} !== {exp_r[7:0], exp_r[8], exp_z, v}) begin
        failures++;
        $display("FAIL stream_%0d op=%0d a=%0d b=%0d ci=%0d v=%0b got s=%0d co=%0b z=%0b ov=%0b want s=%0d co=%0b z=%0b ov=%0b",
                 i, op, a, b, c, v, s, co, zero, out_valid, exp_r[7:0], exp_r[8], exp_z, v);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    opt      = 3'd0;
    numa     = 8'd0;
    numb     = 8'd0;
    ci       = 1'b0;
    #12;
    test_reset();
    test_arith();
    test_logic();
    test_nop_reserved();
    test_hold();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
